issue_arbiter: RTL and testbench

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter.sv | 111 +++++++++++
 tb/tb_issue_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/issue_arbiter.sv
// Issue arbiter for four functional units sharing one result bus (CDB).
// A unit is granted only when its fixed-latency CDB slot is still unclaimed.
module issue_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_req,
    input  logic       ls_req,
    input  logic       mult_req,
    input  logic       div_req,
    output logic       int_grant,
    output logic       ls_grant,
    output logic       mult_grant,
    output logic       div_grant,
    output logic [3:0] cdb_owner,
    output logic       div_busy
);

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_LS   = 2'd1,
        UNIT_MULT = 2'd2,
        UNIT_DIV  = 2'd3
    } unit_e;

    logic [6:0]      res_q, res_d;
    logic [6:0][1:0] owner_q, owner_d;
    logic [1:0]      rr_q, rr_d;
    logic [2:0]      div_cnt_q, div_cnt_d;

    logic [3:0] req_vec;
    logic [3:0] elig;
    logic [3:0] grant_vec;
    logic       grant_valid;
    unit_e      grant_unit;
    logic [2:0] claim_slot;

    assign req_vec  = {div_req, mult_req, ls_req, int_req};
    assign div_busy = (div_cnt_q != 3'd0);

    // Slot L of the current vector is the cycle the result would land in;
    // the divider's slot 7 lies beyond the vector and is always free.
    always_comb begin
        elig = 4'b0000;
        if (reset) begin
            elig[0] = req_vec[0] & ~res_q[1];
            elig[1] = req_vec[1] & ~res_q[2];
            elig[2] = req_vec[2] & ~res_q[4];
            elig[3] = req_vec[3] & ~div_busy;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        grant_valid = 1'b0;
        grant_unit  = UNIT_INT;
        for (int i = 0; i < 4; i++) begin
            if (!grant_valid && elig[rr_q + 2'(i)]) begin
                grant_valid = 1'b1;
                grant_unit  = unit_e'(rr_q + 2'(i));
            end
        end
    end

    assign grant_vec = grant_valid ? (4'b0001 << grant_unit) : 4'b0000;
    assign {div_grant, mult_grant, ls_grant, int_grant} = grant_vec;

    always_comb begin
        case (grant_unit)
            UNIT_INT:  claim_slot = 3'd0;
            UNIT_LS:   claim_slot = 3'd1;
            UNIT_MULT: claim_slot = 3'd3;
            default:   claim_slot = 3'd6;
        endcase
    end

    // The claimed slot after the shift is the slot checked free for eligibility.
    always_comb begin
        res_d     = {1'b0, res_q[6:1]};
        owner_d   = {2'b00, owner_q[6:1]};
        rr_d      = rr_q;
        div_cnt_d = div_busy ? div_cnt_q - 3'd1 : 3'd0;
        if (grant_valid) begin
            res_d[claim_slot]   = 1'b1;
            owner_d[claim_slot] = grant_unit;
            rr_d                = grant_unit + 2'd1;
            if (grant_unit == UNIT_DIV) begin
                div_cnt_d = 3'd7;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q     <= '0;
            owner_q   <= '0;
            rr_q      <= 2'd0;
            div_cnt_q <= 3'd0;
        end else begin
            res_q     <= res_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign cdb_owner = res_q[0] ? (4'b0001 << owner_q[0]) : 4'b0000;

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed bench for issue_arbiter: grant order, CDB slot ownership, divider
// occupancy and asynchronous reset behaviour.
module tb_issue_arbiter;

    logic       clk;
    logic       reset;
    logic       int_req, ls_req, mult_req, div_req;
    logic       int_grant, ls_grant, mult_grant, div_grant;
    logic [3:0] cdb_owner;
    logic       div_busy;
    logic [3:0] grants;
    logic [3:0] reqs;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] t_req  [0:19];
    logic [3:0] t_gnt  [0:19];
    logic [3:0] t_cdb  [0:19];
    logic       t_busy [0:19];
    logic [3:0] sb     [0:39];
    logic [3:0] f_gnt  [0:5];

    issue_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .int_req    (int_req),
        .ls_req     (ls_req),
        .mult_req   (mult_req),
        .div_req    (div_req),
        .int_grant  (int_grant),
        .ls_grant   (ls_grant),
        .mult_grant (mult_grant),
        .div_grant  (div_grant),
        .cdb_owner  (cdb_owner),
        .div_busy   (div_busy)
    );

    assign grants = {div_grant, mult_grant, ls_grant, int_grant};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        reqs     = r;
        int_req  = r[0];
        ls_req   = r[1];
        mult_req = r[2];
        div_req  = r[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b0;
        set_req(4'b0000);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_table(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            if (c > 0) tick();
            set_req(t_req[c]);
            #1;
            check($sformatf("%s gnt c%0d", name, c), grants, t_gnt[c]);
            check($sformatf("%s cdb c%0d", name, c), cdb_owner, t_cdb[c]);
            check($sformatf("%s busy c%0d", name, c), {3'b000, div_busy}, {3'b000, t_busy[c]});
        end
    endtask

    initial begin
        reset = 1'b0;
        set_req(4'b1111);
        tick();
        tick();
        check("rst gnt", grants, 4'b0000);
        check("rst cdb", cdb_owner, 4'b0000);
        check("rst busy", {3'b000, div_busy}, 4'b0000);

        // All four requests held: round-robin from int, results land at 1,3,6,10.
        reset = 1'b1;
        t_req  = '{0: 4'b1111, 1: 4'b1111, 2: 4'b1111, 3: 4'b1111, default: 4'b0000};
        t_gnt  = '{0: 4'b0001, 1: 4'b0010, 2: 4'b0100, 3: 4'b1000, default: 4'b0000};
        t_cdb  = '{1: 4'b0001, 3: 4'b0010, 6: 4'b0100, 10: 4'b1000, default: 4'b0000};
        t_busy = '{4: 1'b1, 5: 1'b1, 6: 1'b1, 7: 1'b1, 8: 1'b1, 9: 1'b1, 10: 1'b1, default: 1'b0};
        run_table(12, "all4");

        // Int blocked at cycle 3 by the mult result owning cycle 4.
        do_reset();
        t_req  = '{0: 4'b0100, 3: 4'b0001, 4: 4'b0001, default: 4'b0000};
        t_gnt  = '{0: 4'b0100, 4: 4'b0001, default: 4'b0000};
        t_cdb  = '{4: 4'b0100, 5: 4'b0001, default: 4'b0000};
        t_busy = '{default: 1'b0};
        run_table(7, "intblk");

        // Divider is non-pipelined: second issue waits for the counter to drain.
        do_reset();
        t_req  = '{0: 4'b1000, 1: 4'b1000, 2: 4'b1000, 3: 4'b1000, 4: 4'b1000,
                   5: 4'b1000, 6: 4'b1000, 7: 4'b1000, 8: 4'b1000, default: 4'b0000};
        t_gnt  = '{0: 4'b1000, 8: 4'b1000, default: 4'b0000};
        t_cdb  = '{7: 4'b1000, 15: 4'b1000, default: 4'b0000};
        t_busy = '{1: 1'b1, 2: 1'b1, 3: 1'b1, 4: 1'b1, 5: 1'b1, 6: 1'b1, 7: 1'b1,
                   9: 1'b1, 10: 1'b1, 11: 1'b1, 12: 1'b1, 13: 1'b1, 14: 1'b1, 15: 1'b1,
                   default: 1'b0};
        run_table(17, "div");

        // One-cycle ls request collides with the mult slot and is dropped.
        do_reset();
        t_req  = '{0: 4'b0100, 2: 4'b0010, default: 4'b0000};
        t_gnt  = '{0: 4'b0100, default: 4'b0000};
        t_cdb  = '{4: 4'b0100, default: 4'b0000};
        t_busy = '{default: 1'b0};
        run_table(8, "lscol");

        // Asynchronous reset with reservations outstanding.
        do_reset();
        set_req(4'b1000);
        #1;
        check("arst gnt c0", grants, 4'b1000);
        tick();
        set_req(4'b0001);
        #1;
        check("arst gnt c1", grants, 4'b0001);
        check("arst busy c1", {3'b000, div_busy}, 4'b0001);
        tick();
        set_req(4'b0100);
        #1;
        check("arst gnt c2", grants, 4'b0100);
        check("arst cdb c2", cdb_owner, 4'b0001);
        tick();
        set_req(4'b0011);
        #1;
        check("arst gnt c3", grants, 4'b0001);
        check("arst busy c3", {3'b000, div_busy}, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("arst gnt low", grants, 4'b0000);
        check("arst cdb low", cdb_owner, 4'b0000);
        check("arst busy low", {3'b000, div_busy}, 4'b0000);
        set_req(4'b0000);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            #1;
            check($sformatf("post cdb c%0d", c), cdb_owner, 4'b0000);
            check($sformatf("post busy c%0d", c), {3'b000, div_busy}, 4'b0000);
        end

        // Int and mult held: hand-derived first grants, then slot scoreboard.
        do_reset();
        f_gnt = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
        for (int k = 0; k < 40; k++) sb[k] = 4'b0000;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) tick();
            set_req((c < 20) ? 4'b0101 : 4'b0000);
            #1;
            check($sformatf("mix cdb c%0d", c), cdb_owner, sb[c]);
            check($sformatf("mix legal c%0d", c), grants & ~reqs, 4'b0000);
            if (c < 20) check($sformatf("mix any c%0d", c), {3'b000, |grants}, 4'b0001);
            if (c < 6) check($sformatf("mix order c%0d", c), grants, f_gnt[c]);
            if (grants == 4'b0001) begin
                check($sformatf("mix slot int c%0d", c), sb[c+1], 4'b0000);
                sb[c+1] = 4'b0001;
            end else if (grants == 4'b0100) begin
                check($sformatf("mix slot mult c%0d", c), sb[c+4], 4'b0000);
                sb[c+4] = 4'b0100;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
